// File: rtl/wb_spi_master.sv
// Wishbone-attached SPI master: one 8-bit transfer per DATA write, mode 0
// (CPOL=0 / CPHA=0), MSB first, programmable SCK half-period and eight
// directly driven chip selects.
module wb_spi_master #(
    parameter int          clk_freq = 50000000,
    parameter logic [15:0] div_init = 16'd24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        intr,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [7:0]  spi_cs_n
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DIV    = 2'd2;
    localparam logic [1:0] ADR_CS     = 2'd3;
    localparam logic [31:0] CLK_FREQ_C = clk_freq;

    state_t      state_q, state_d;
    logic        ack_q;
    logic [31:0] dat_q, dat_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  cs_q, cs_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  edge_q, edge_d;
    logic [7:0]  shift_q, shift_d;
    logic        miso_q, miso_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;

    logic        access_s, wr_s, rd_s, busy_s, start_s, tick_s, done_s;
    logic [1:0]  reg_sel_s;
    logic        unused_s;

    // Byte selects, undecoded address bits and the clock frequency are informational only.
    assign unused_s = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], CLK_FREQ_C[0]};

    assign access_s  = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr_s      = access_s & wb_we_i;
    assign rd_s      = access_s & ~wb_we_i;
    assign reg_sel_s = wb_adr_i[3:2];
    assign busy_s    = (state_q == ST_XFER);
    assign start_s   = wr_s & (reg_sel_s == ADR_DATA) & ~busy_s;
    assign tick_s    = busy_s & (cnt_q == 16'd0);
    assign done_s    = tick_s & (edge_q == 4'd15);

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign intr     = rx_valid_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_q;

    // Engine state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Engine next state: start on an idle DATA write, stop after the 16th SCK edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_XFER;
                else         state_d = ST_IDLE;
            end
            ST_XFER: begin
                if (done_s) state_d = ST_IDLE;
                else        state_d = ST_XFER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine outputs: half-period timing, SCK toggling, sampling on rise, shifting on fall.
    always_comb begin
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        shift_d   = shift_q;
        miso_d    = miso_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        rx_data_d = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    cnt_d   = div_q;
                    edge_d  = 4'd0;
                    shift_d = wb_dat_i[7:0];
                    sck_d   = 1'b0;
                    mosi_d  = wb_dat_i[7];
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_XFER: begin
                if (tick_s) begin
                    cnt_d  = div_q;
                    edge_d = edge_q + 4'd1;
                    sck_d  = ~sck_q;
                    if (!sck_q) begin
                        miso_d = spi_miso;
                    end else begin
                        shift_d = {shift_q[6:0], miso_q};
                        // The final falling edge leaves MOSI on bit0 of the sent byte.
                        if (done_s) rx_data_d = {shift_q[6:0], miso_q};
                        else        mosi_d    = shift_q[6];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Register file next state: writes, read data mux and rx_valid set/clear.
    always_comb begin
        div_d      = div_q;
        cs_d       = cs_q;
        dat_d      = dat_q;
        rx_valid_d = rx_valid_q;
        if (wr_s) begin
            case (reg_sel_s)
                ADR_DIV: div_d = wb_dat_i[15:0];
                ADR_CS:  cs_d  = wb_dat_i[7:0];
                default: div_d = div_q;
            endcase
        end else begin
            div_d = div_q;
        end
        if (access_s) begin
            case (reg_sel_s)
                ADR_DATA:   dat_d = {24'd0, rx_data_q};
                ADR_STATUS: dat_d = {30'd0, rx_valid_q, busy_s};
                ADR_DIV:    dat_d = {16'd0, div_q};
                ADR_CS:     dat_d = {24'd0, cs_q};
                default:    dat_d = 32'd0;
            endcase
        end else begin
            dat_d = dat_q;
        end
        // Completion wins over a DATA read clearing in the same cycle.
        if (done_s) begin
            rx_valid_d = 1'b1;
        end else if (rd_s && (reg_sel_s == ADR_DATA)) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Datapath and bus registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            div_q      <= div_init;
            cs_q       <= 8'hFF;
            cnt_q      <= 16'd0;
            edge_q     <= 4'd0;
            shift_q    <= 8'd0;
            miso_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            ack_q      <= access_s;
            dat_q      <= dat_d;
            div_q      <= div_d;
            cs_q       <= cs_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            shift_q    <= shift_d;
            miso_q     <= miso_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_wb_spi_master.sv
// Directed bench for wb_spi_master: a transfer-level model predicts SCK, MOSI,
// interrupt and chip selects every cycle; register reads are checked against
// hand-computed values.
module tb_wb_spi_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [3:0]  wb_sel_i;
    logic        intr, spi_sck, spi_mosi, spi_miso;
    logic [7:0]  spi_cs_n;
    logic        loop_en, miso_const;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Transfer-level model.
    logic        en;
    logic        m_act;
    int          m_e, m_d, m_done, m_clr;
    logic [7:0]  m_tx, m_cs;
    logic [15:0] m_div;

    // Observers.
    logic        prev_sck, prev_intr;
    int          rises, intr_rises;
    logic [7:0]  cap;
    int          last_acc;

    // Compare-process scratch.
    int          c_m, c_e, c_hp;
    logic        sck_x, mosi_x, intr_x;

    assign spi_miso = loop_en ? spi_mosi : miso_const;

    always #5 clk = ~clk;

    always @(posedge clk) n <= n + 1;

    wb_spi_master #(.clk_freq(50000000), .div_init(16'd24)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .intr(intr),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (en) begin
            sck_x  = 1'b0;
            mosi_x = 1'b0;
            intr_x = 1'b0;
            if (m_act) begin
                c_hp = m_d + 1;
                c_m  = n - m_e;
                if (c_m < 16 * c_hp) begin
                    c_e    = c_m / c_hp;
                    sck_x  = (c_e % 2) == 1;
                    mosi_x = m_tx[7 - c_e / 2];
                end else begin
                    sck_x  = 1'b0;
                    mosi_x = m_tx[0];
                end
                intr_x = (n >= m_done) && !((m_clr > m_done) && (n >= m_clr));
            end
            chk("sck",  {31'd0, spi_sck},  {31'd0, sck_x});
            chk("mosi", {31'd0, spi_mosi}, {31'd0, mosi_x});
            chk("intr", {31'd0, intr},     {31'd0, intr_x});
            chk("cs_n", {24'd0, spi_cs_n}, {24'd0, m_cs});
            if (prev_sck === 1'b0 && spi_sck === 1'b1) begin
                rises = rises + 1;
                cap   = {cap[6:0], spi_mosi};
            end
            if (prev_intr === 1'b0 && intr === 1'b1) intr_rises = intr_rises + 1;
        end
        prev_sck  = spi_sck;
        prev_intr = intr;
    end

    // One Wishbone access; called just after a rising edge, returns just after one.
    task automatic wb(input logic we, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
        int acc;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
        wb_adr_i = 32'h5A50_0000 | {28'd0, a};
        wb_dat_i = d; wb_sel_i = 4'h3;
        @(posedge clk); #1;
        acc = n;
        last_acc = acc;
        chk("ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (we) begin
            case (a[3:2])
                2'd0: begin
                    if (!(m_act && acc <= m_done)) begin
                        m_act  = 1'b1;
                        m_e    = acc;
                        m_d    = int'(m_div);
                        m_tx   = d[7:0];
                        m_done = acc + 16 * (int'(m_div) + 1);
                        m_clr  = 0;
                    end
                end
                2'd2: m_div = d[15:0];
                2'd3: m_cs  = d[7:0];
                default: ;
            endcase
        end else if (a[3:2] == 2'd0) begin
            m_clr = acc;
        end
        @(posedge clk); #1;
        chk("ack_single", {31'd0, wb_ack_o}, 32'd0);
    endtask

    task automatic wait_to(input int k);
        while (n < k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_intr(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (intr === 1'b1) begin
                at = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_act = 1'b0; m_div = 16'd24; m_cs = 8'hFF; m_clr = 0;
    endtask

    initial begin
        logic [31:0] rd;
        int at, e0, snap;
        reset_n = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'h0;
        loop_en = 1'b1; miso_const = 1'b0; en = 1'b0;
        m_act = 1'b0; m_e = 0; m_d = 0; m_done = 0; m_clr = 0;
        m_tx = 8'd0; m_cs = 8'hFF; m_div = 16'd24;
        rises = 0; intr_rises = 0; cap = 8'd0; last_acc = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        en = 1'b1;

        // Reset values.
        wb(1'b0, 4'h8, 32'd0, rd); chk("rst_div",    rd, 32'd24);
        wb(1'b0, 4'hC, 32'd0, rd); chk("rst_cs",     rd, 32'h0000_00FF);
        wb(1'b0, 4'h4, 32'd0, rd); chk("rst_status", rd, 32'd0);
        wb(1'b0, 4'h0, 32'd0, rd); chk("rst_data",   rd, 32'd0);

        // Loopback, DIVISOR=0, 0xA5.
        loop_en = 1'b1;
        wb(1'b1, 4'h8, 32'd0, rd);
        rises = 0;
        wb(1'b1, 4'h0, 32'hFFFF_FFA5, rd);
        e0 = last_acc;
        wait_intr(100, at);
        chk("dur_a5", at - e0, 32'd16);
        chk("rises_a5", rises, 32'd8);
        chk("mosi_a5", {24'd0, cap}, 32'h0000_00A5);
        wb(1'b0, 4'h4, 32'd0, rd); chk("status_done_a5", rd, 32'h2);
        wb(1'b0, 4'h0, 32'd0, rd); chk("data_a5", rd, 32'h0000_00A5);
        wb(1'b0, 4'h4, 32'd0, rd); chk("status_clr_a5", rd, 32'h0);

        // DIVISOR=24, 0x3C, MISO held high.
        loop_en = 1'b0; miso_const = 1'b1;
        wb(1'b1, 4'h8, 32'd24, rd);
        rises = 0;
        wb(1'b1, 4'h0, 32'h0000_003C, rd);
        e0 = last_acc;
        wb(1'b0, 4'h4, 32'd0, rd); chk("status_busy_3c", rd, 32'h1);
        wait_intr(600, at);
        chk("dur_3c", at - e0, 32'd400);
        chk("rises_3c", rises, 32'd8);
        chk("mosi_3c", {24'd0, cap}, 32'h0000_003C);
        wb(1'b0, 4'h0, 32'd0, rd); chk("data_3c", rd, 32'h0000_00FF);

        // Second DATA write while busy is ignored.
        loop_en = 1'b1;
        wb(1'b1, 4'h8, 32'd2, rd);
        rises = 0; intr_rises = 0;
        wb(1'b1, 4'h0, 32'h0000_0011, rd);
        e0 = last_acc;
        wb(1'b1, 4'h0, 32'h0000_0022, rd);
        wait_intr(200, at);
        chk("dur_11", at - e0, 32'd48);
        wb(1'b0, 4'h0, 32'd0, rd); chk("data_11", rd, 32'h0000_0011);
        repeat (60) begin @(posedge clk); #1; end
        chk("rises_11", rises, 32'd8);
        chk("mosi_11", {24'd0, cap}, 32'h0000_0011);
        chk("intr_once", intr_rises, 32'd1);

        // CS register and ack spacing under a held strobe.
        wb(1'b1, 4'hC, 32'hFFFF_FFFE, rd);
        chk("cs_pins", {24'd0, spi_cs_n}, 32'h0000_00FE);
        wb(1'b0, 4'hC, 32'd0, rd); chk("cs_read", rd, 32'h0000_00FE);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_000C;
        @(posedge clk); #1; chk("hold_ack1", {31'd0, wb_ack_o}, 32'd1);
        @(posedge clk); #1; chk("hold_ack2", {31'd0, wb_ack_o}, 32'd0);
        @(posedge clk); #1; chk("hold_ack3", {31'd0, wb_ack_o}, 32'd1);
        chk("hold_dat", wb_dat_o, 32'h0000_00FE);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(posedge clk); #1; chk("hold_ack4", {31'd0, wb_ack_o}, 32'd0);

        // Reset after five SCK edges aborts the transfer.
        wb(1'b1, 4'h8, 32'd1, rd);
        rises = 0; intr_rises = 0;
        wb(1'b1, 4'h0, 32'h0000_0096, rd);
        e0 = last_acc;
        wait_to(e0 + 10);
        do_reset();
        snap = rises;
        wb(1'b0, 4'h4, 32'd0, rd); chk("status_after_rst", rd, 32'h0);
        wb(1'b0, 4'h8, 32'd0, rd); chk("div_after_rst", rd, 32'd24);
        wb(1'b0, 4'hC, 32'd0, rd); chk("cs_after_rst", rd, 32'h0000_00FF);
        repeat (20) begin @(posedge clk); #1; end
        chk("no_sck_after_rst", rises, snap);
        chk("no_intr_after_rst", intr_rises, 32'd0);
        wb(1'b1, 4'h8, 32'd0, rd);
        wb(1'b1, 4'h0, 32'h0000_005A, rd);
        e0 = last_acc;
        wait_intr(100, at);
        chk("dur_5a", at - e0, 32'd16);
        wb(1'b0, 4'h0, 32'd0, rd); chk("data_5a", rd, 32'h0000_005A);

        // DATA read in the completion cycle keeps rx_valid.
        wb(1'b1, 4'h0, 32'h0000_00C3, rd);
        e0 = last_acc;
        wait_to(e0 + 15);
        wb(1'b0, 4'h0, 32'd0, rd); chk("data_coincide_old", rd, 32'h0000_005A);
        wb(1'b0, 4'h4, 32'd0, rd); chk("status_coincide", rd, 32'h2);
        wb(1'b0, 4'h0, 32'd0, rd); chk("data_c3", rd, 32'h0000_00C3);
        wb(1'b0, 4'h4, 32'd0, rd); chk("status_final", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_spi_master.md
WB_SPI_MASTER -- requirements
Module: wb_spi_master

Interface
REQ-001 SHALL have parameter clk_freq, default 50000000, system clock frequency in Hz (informational; used by software constants).
REQ-002 SHALL have parameter div_init, default 16'd24, reset value of the DIVISOR register (1 MHz SCK at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port wb_adr_i  input  32  byte address; only [3:2] decoded.
REQ-006 SHALL have port wb_dat_i  input  32  write data.
REQ-007 SHALL have port wb_dat_o  output  32  read data.
REQ-008 SHALL have ports wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  Wishbone strobe, cycle and write enable.
REQ-009 SHALL have port wb_sel_i  input  4  byte selects; ignored, full-word access.
REQ-010 SHALL have port wb_ack_o  output  1  Wishbone acknowledge.
REQ-011 SHALL have port intr  output  1  level interrupt, equals rx_valid.
REQ-012 SHALL have ports spi_sck, spi_mosi  output  1 each  SPI clock and data out.
REQ-013 SHALL have port spi_miso  input  1  SPI data in.
REQ-014 SHALL have port spi_cs_n  output  8  chip selects, driven directly from the CS register.

Function
REQ-015 SHALL decode the register map on wb_adr_i[3:2]: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CS.
REQ-016 SHALL register wb_ack_o as stb&cyc&~ack, giving one ack per access, one cycle after strobe, and never on consecutive cycles.
REQ-017 SHALL perform register writes and read side effects in the cycle where stb&cyc&~ack is true.
REQ-018 SHALL register wb_dat_o in that same cycle; unused bits read 0.
REQ-019 DATA write when idle SHALL load wb_dat_i[7:0] into the shift register and make busy=1 from the next cycle.
REQ-020 DATA write while busy SHALL be acked and otherwise ignored.
REQ-021 DATA read SHALL return rx_data[7:0] and clear rx_valid; a clear coinciding with transfer completion SHALL leave rx_valid=1.
REQ-022 STATUS read SHALL return {30'b0, rx_valid, busy}; STATUS writes are ignored.
REQ-023 DIVISOR SHALL be 16 bits, read/write; a write while busy takes effect from the next half-period reload.
REQ-024 CS SHALL be 8 bits, read/write, and is not touched by the engine.
REQ-025 The engine FSM SHALL have states IDLE and XFER, with fixed mode CPOL=0 / CPHA=0, MSB first, 8 bits.
REQ-026 On entering XFER, spi_sck SHALL be 0, spi_mosi SHALL be bit7, the half-period counter SHALL be DIVISOR, and the edge counter SHALL be 0.
REQ-027 In XFER, the counter SHALL decrement each cycle; at 0 it SHALL reload DIVISOR, toggle spi_sck and increment the edge counter.
REQ-028 On each rising SCK edge, spi_miso SHALL be sampled into the shift-register LSB side.
REQ-029 On each falling SCK edge, the shift register SHALL shift left and spi_mosi SHALL present the next bit.
REQ-030 After the 16th edge, the FSM SHALL return to IDLE with sck=0, rx_data=received byte, rx_valid=1, busy=0.
REQ-031 Transfer duration from busy rising to busy falling SHALL be exactly 16*(DIVISOR+1) cycles.
REQ-032 spi_mosi SHALL hold the last shifted value (bit0 of tx byte) in IDLE.

Reset
REQ-033 While reset_n=0 at a clock edge, the block SHALL set: FSM=IDLE, busy=0, rx_valid=0, rx_data=0, DIVISOR=div_init, CS=8'hFF, spi_sck=0, spi_mosi=0, wb_ack_o=0, wb_dat_o=0, intr=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer immediately with no rx_valid and no further SCK edges.

Verification
REQ-035 Loopback (miso=mosi), DIVISOR=0, DATA write 0xA5 -> 8 SCK pulses, busy high 16 cycles, DATA read 0xA5, intr 1 then 0 after the read.
REQ-036 DIVISOR=24, write 0x3C, miso held 1 -> mosi bits 0,0,1,1,1,1,0,0, busy high 400 cycles, rx_data=0xFF.
REQ-037 DATA write 0x11 then 0x22 during busy -> only 0x11 shifted out, both writes acked, single rx_valid.
REQ-038 CS write 0xFE, read back -> spi_cs_n=0xFE, wb_dat_o=0x000000FE; after reset CS reads 0xFF and DIVISOR reads 24.
REQ-039 reset_n low for 1 cycle after 5 SCK edges -> sck=0, busy=0, rx_valid=0 next cycle; new transfer then completes normally.
REQ-040 DATA read in the completion cycle -> rx_valid remains 1, STATUS reads 0x2.
